// File: rtl/cam.sv
// ---------------------------------------------------------------------------
// cam -- content-addressable memory with per-entry valid bits.
//
// Stores DEPTH entries of DATA_WIDTH bits. Writes land on the rising clock
// edge. Reads and searches are purely combinational from the stored state.
// When a write hits the same entry in the same cycle, a read or search
// returns the old contents. Search reports the lowest matching valid entry.
//
// Ports
//   clk           in   sole clock, rising edge
//   reset         in   synchronous, active-low; clears data and valid bits
//   read          in   read enable
//   read_index    in   entry to read
//   write         in   write enable
//   write_index   in   entry to write
//   write_data    in   data to store
//   search        in   search enable
//   search_data   in   key to match
//   read_valid    out  addressed entry holds valid data (0 when read=0)
//   read_value    out  data of addressed entry (0 when invalid or read=0)
//   search_valid  out  at least one valid entry matches the key
//   search_index  out  lowest matching index (0 when no match or search=0)
// ---------------------------------------------------------------------------
module cam #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   read,
    input  logic [INDEX_WIDTH-1:0] read_index,
    input  logic                   write,
    input  logic [INDEX_WIDTH-1:0] write_index,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic                   search,
    input  logic [DATA_WIDTH-1:0]  search_data,
    output logic                   read_valid,
    output logic [DATA_WIDTH-1:0]  read_value,
    output logic                   search_valid,
    output logic [INDEX_WIDTH-1:0] search_index
);

    logic [DATA_WIDTH-1:0] entry_data [DEPTH];
    logic [DEPTH-1:0]      entry_valid;
    logic [DEPTH-1:0]      match;

    // Storage update. Reset wins over a concurrent write and clears the
    // data as well as the valid bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            entry_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_data[i] <= '0;
            end
        end else if (write) begin
            entry_data[write_index]  <= write_data;
            entry_valid[write_index] <= 1'b1;
        end
    end

    // Read port.
    always_comb begin
        read_valid = 1'b0;
        read_value = '0;
        if (read) begin
            read_valid = entry_valid[read_index];
            if (entry_valid[read_index]) begin
                read_value = entry_data[read_index];
            end
        end
    end

    // Parallel compare; invalid entries are masked out so they never match.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = entry_valid[i] && (entry_data[i] == search_data);
        end
    end

    // Fixed-priority encode: scanning from the top down leaves the lowest
    // matching index as the final assignment.
    always_comb begin
        search_valid = 1'b0;
        search_index = '0;
        if (search) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (match[i]) begin
                    search_valid = 1'b1;
                    search_index = INDEX_WIDTH'(i);
                end
            end
        end
    end

endmodule

// File: tb/tb_cam.sv
// ---------------------------------------------------------------------------
// tb_cam -- directed, self-checking bench for cam.
//
// Each step drives inputs at the falling edge, pushes the expected outputs
// into a scoreboard queue, and pops/compares them shortly afterwards while
// the clock is still low.
// ---------------------------------------------------------------------------
module tb_cam;

    localparam int DW = 32;
    localparam int IW = 5;

    logic          clk;
    logic          reset;
    logic          read;
    logic [IW-1:0] read_index;
    logic          write;
    logic [IW-1:0] write_index;
    logic [DW-1:0] write_data;
    logic          search;
    logic [DW-1:0] search_data;
    logic          read_valid;
    logic [DW-1:0] read_value;
    logic          search_valid;
    logic [IW-1:0] search_index;

    cam #(.DATA_WIDTH(DW), .DEPTH(32), .INDEX_WIDTH(IW)) dut (
        .clk          (clk),
        .reset        (reset),
        .read         (read),
        .read_index   (read_index),
        .write        (write),
        .write_index  (write_index),
        .write_data   (write_data),
        .search       (search),
        .search_data  (search_data),
        .read_valid   (read_valid),
        .read_value   (read_value),
        .search_valid (search_valid),
        .search_index (search_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 read_valid, 1 read_value, 2 search_valid, 3 search_index
    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input int kind, input logic [31:0] exp, input string tag);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.tag  = tag;
        q.push_back(e);
    endtask

    task automatic exp_read(input logic v, input logic [31:0] val, input string tag);
        push(0, {31'b0, v}, {tag, ".read_valid"});
        push(1, val, {tag, ".read_value"});
    endtask

    task automatic exp_search(input logic v, input logic [31:0] idx, input string tag);
        push(2, {31'b0, v}, {tag, ".search_valid"});
        push(3, idx, {tag, ".search_index"});
    endtask

    task automatic compare();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                0:       obs = {31'b0, read_valid};
                1:       obs = read_value;
                2:       obs = {31'b0, search_valid};
                default: obs = {27'b0, search_index};
            endcase
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Start a step: wait for the falling edge and return all controls to idle.
    task automatic begin_step();
        @(negedge clk);
        reset       = 1'b1;
        read        = 1'b0;
        read_index  = '0;
        write       = 1'b0;
        write_index = '0;
        write_data  = '0;
        search      = 1'b0;
        search_data = '0;
    endtask

    task automatic do_write(input int idx, input logic [31:0] d);
        begin_step();
        write       = 1'b1;
        write_index = IW'(idx);
        write_data  = d;
    endtask

    task automatic check_read(input int idx, input logic v, input logic [31:0] val, input string tag);
        begin_step();
        read       = 1'b1;
        read_index = IW'(idx);
        exp_read(v, val, tag);
        compare();
    endtask

    task automatic check_search(input logic [31:0] key, input logic v, input int idx, input string tag);
        begin_step();
        search      = 1'b1;
        search_data = key;
        exp_search(v, 32'(idx), tag);
        compare();
    endtask

    initial begin
        reset = 1'b0; read = 1'b0; read_index = '0; write = 1'b0;
        write_index = '0; write_data = '0; search = 1'b0; search_data = '0;
        repeat (2) @(posedge clk);

        // Reset state: everything reads back as zero.
        begin_step();
        read = 1'b1; read_index = 5'd0; search = 1'b1; search_data = 32'd0;
        exp_read(1'b0, 32'd0, "rst_r0");
        exp_search(1'b0, 32'd0, "rst_s0");
        compare();

        // Scenario 1: write 0,1,1,3 into entries 0..3 and read 0..4.
        do_write(0, 32'd0);
        do_write(1, 32'd1);
        do_write(2, 32'd1);
        do_write(3, 32'd3);
        check_read(0, 1'b1, 32'd0, "s1_r0");
        check_read(1, 1'b1, 32'd1, "s1_r1");
        check_read(2, 1'b1, 32'd1, "s1_r2");
        check_read(3, 1'b1, 32'd3, "s1_r3");
        check_read(4, 1'b0, 32'd0, "s1_r4");

        // Enables low: outputs forced to zero even with matching inputs.
        begin_step();
        read_index = 5'd3; search_data = 32'd3;
        exp_read(1'b0, 32'd0, "idle_r");
        exp_search(1'b0, 32'd0, "idle_s");
        compare();

        // Scenario 2: searches, including duplicate priority and a miss.
        check_search(32'd0, 1'b1, 0, "s2_k0");
        check_search(32'd1, 1'b1, 1, "s2_k1");
        check_search(32'd3, 1'b1, 3, "s2_k3");
        check_search(32'd2, 1'b0, 0, "s2_k2");

        // Scenario 3: same-cycle write/read/search of entry 3 sees old data.
        begin_step();
        write = 1'b1; write_index = 5'd3; write_data = 32'd4;
        read = 1'b1; read_index = 5'd3;
        search = 1'b1; search_data = 32'd3;
        exp_read(1'b1, 32'd3, "s3_pre_r");
        exp_search(1'b1, 32'd3, "s3_pre_s");
        compare();
        check_read(3, 1'b1, 32'd4, "s3_post_r");
        check_search(32'd4, 1'b1, 3, "s3_post_s");

        // Scenario 4: write entry 2 while reading 1 and searching 0.
        begin_step();
        write = 1'b1; write_index = 5'd2; write_data = 32'd4;
        read = 1'b1; read_index = 5'd1;
        search = 1'b1; search_data = 32'd0;
        exp_read(1'b1, 32'd1, "s4_pre_r");
        exp_search(1'b1, 32'd0, "s4_pre_s");
        compare();
        check_search(32'd4, 1'b1, 2, "s4_post_s");

        // Top index and all-ones data.
        do_write(31, 32'hFFFF_FFFF);
        check_read(31, 1'b1, 32'hFFFF_FFFF, "top_r");
        check_search(32'hFFFF_FFFF, 1'b1, 31, "top_s");

        // Scenario 5: one reset edge wipes everything.
        begin_step();
        reset = 1'b0;
        begin_step();
        read = 1'b1; read_index = 5'd0; search = 1'b1; search_data = 32'd0;
        exp_read(1'b0, 32'd0, "s5_r0");
        exp_search(1'b0, 32'd0, "s5_s0");
        compare();
        for (int i = 1; i <= 4; i++) begin
            check_read(i, 1'b0, 32'd0, $sformatf("s5_r%0d", i));
        end
        check_read(31, 1'b0, 32'd0, "s5_r31");
        check_search(32'hFFFF_FFFF, 1'b0, 0, "s5_stop");

        // Scenario 6: reset beats a concurrent write and discards prior data.
        do_write(6, 32'd9);
        check_read(6, 1'b1, 32'd9, "s6_pre_r6");
        begin_step();
        reset = 1'b0; write = 1'b1; write_index = 5'd5; write_data = 32'd7;
        check_read(5, 1'b0, 32'd0, "s6_r5");
        check_search(32'd7, 1'b0, 0, "s6_s7");
        check_read(6, 1'b0, 32'd0, "s6_r6");
        check_search(32'd9, 1'b0, 0, "s6_s9");

        // Writes resume normally after reset.
        do_write(5, 32'd7);
        check_read(5, 1'b1, 32'd7, "s6_rewrite_r");
        check_search(32'd7, 1'b1, 5, "s6_rewrite_s");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
